// File: rtl/program_fetch_store_if.sv
// Handshake and bus bundle for the program store / fetch sequencer.
// master drives load/control inputs, slave (the store) drives issue outputs.
interface program_fetch_store_if #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 5
);
    logic                  loadEn;
    logic [ADDR_WIDTH-1:0] loadAddr;
    logic [DATA_WIDTH-1:0] loadData;
    logic                  start;
    logic [ADDR_WIDTH-1:0] endAddrIn;
    logic                  stallIn;
    logic                  skipIn;
    logic                  stopIn;
    logic [DATA_WIDTH-1:0] instrOut;
    logic [ADDR_WIDTH-1:0] pcOut;
    logic                  instrValid;
    logic                  busy;
    logic                  done;

    modport master (
        output loadEn, loadAddr, loadData,
        output start, endAddrIn,
        output stallIn, skipIn, stopIn,
        input  instrOut, pcOut, instrValid,
        input  busy, done
    );

    modport slave (
        input  loadEn, loadAddr, loadData,
        input  start, endAddrIn,
        input  stallIn, skipIn, stopIn,
        output instrOut, pcOut, instrValid,
        output busy, done
    );
endinterface

// File: rtl/program_fetch_store.sv
// Writable program store with one-issue-per-cycle fetch sequencer.
// Optional macro PROGFETCH_LOOP_EN: wrap past endAddr instead of DONE.
module program_fetch_store #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] NOP_OPCODE =
        DATA_WIDTH'(4'b0111)
) (
    input  logic clk,
    input  logic reset,
    program_fetch_store_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      written;

    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] end_q, end_d;
    logic                  valid_q, valid_d;
    logic [PW-1:0]         ptr_q, ptr_d;

    logic [PW-1:0]         nxt;
    logic [PW-1:0]         lim;
    logic                  skip_now;
    logic                  load_ok;

    logic [ADDR_WIDTH-1:0] addr0, addr1;
    logic [DATA_WIDTH-1:0] word0, word1;

    assign load_ok  = bus.loadEn && (state != RUN);
    assign skip_now = bus.skipIn & valid_q;
    assign lim      = {1'b0, end_q};
    assign nxt      = ptr_q + PW'(skip_now);

    // Two read ports: the plain next word and the one after it (skip).
    assign addr0 = ptr_q[ADDR_WIDTH-1:0];
    assign addr1 = addr0 + ADDR_WIDTH'(1);
    assign word0 = written[addr0] ? mem[addr0] : NOP_OPCODE;
    assign word1 = written[addr1] ? mem[addr1] : NOP_OPCODE;

`ifdef PROGFETCH_LOOP_EN
    logic [PW-1:0]         wrap;
    logic [ADDR_WIDTH-1:0] wrap_addr;
    logic [DATA_WIDTH-1:0] wrap_word;

    assign wrap      = nxt - lim - PW'(1);
    assign wrap_addr = wrap[ADDR_WIDTH-1:0];
    assign wrap_word = written[wrap_addr] ? mem[wrap_addr]
                                          : NOP_OPCODE;
`endif

    // Next-state and next-issue decode.
    always_comb begin
        state_next = state;
        instr_d    = instr_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        ptr_d      = ptr_q;
        end_d      = end_q;
        unique case (state)
            IDLE, DONE: begin
                if (bus.start && !bus.loadEn) begin
                    state_next = RUN;
                    end_d      = bus.endAddrIn;
                    ptr_d      = '0;
                    valid_d    = 1'b0;
                    instr_d    = NOP_OPCODE;
                end
            end
            RUN: begin
                if (bus.stopIn) begin
                    state_next = DONE;
                    valid_d    = 1'b0;
                    instr_d    = NOP_OPCODE;
                end else if (!bus.stallIn) begin
                    if (nxt > lim) begin
`ifdef PROGFETCH_LOOP_EN
                        pc_d    = wrap_addr;
                        instr_d = wrap_word;
                        valid_d = 1'b1;
                        ptr_d   = wrap + PW'(1);
`else
                        state_next = DONE;
                        valid_d    = 1'b0;
                        instr_d    = NOP_OPCODE;
`endif
                    end else begin
                        pc_d    = nxt[ADDR_WIDTH-1:0];
                        instr_d = skip_now ? word1 : word0;
                        valid_d = 1'b1;
                        ptr_d   = nxt + PW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and issue registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            instr_q <= NOP_OPCODE;
            pc_q    <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
            end_q   <= '0;
        end else begin
            state   <= state_next;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            end_q   <= end_d;
        end
    end

    // Program storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem[bus.loadAddr] <= bus.loadData;
        end
    end

    // Per-word written flags; reset erases the program.
    always_ff @(posedge clk) begin
        if (reset) begin
            written <= '0;
        end else if (load_ok) begin
            written[bus.loadAddr] <= 1'b1;
        end
    end

    assign bus.instrOut   = instr_q;
    assign bus.pcOut      = pc_q;
    assign bus.instrValid = valid_q;
    assign bus.busy       = (state == RUN);
    assign bus.done       = (state == DONE);
endmodule

// File: tb/tb_program_fetch_store.sv
// Directed testbench for program_fetch_store.
// Expected issue sequences are hand-derived per scenario.
module tb_program_fetch_store;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    program_fetch_store_if #(.DATA_WIDTH(4), .ADDR_WIDTH(5)) bus ();

    program_fetch_store #(
        .DATA_WIDTH(4),
        .ADDR_WIDTH(5),
        .NOP_OPCODE(4'b0111)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic load(input int a, input logic [3:0] d);
        bus.loadEn   = 1'b1;
        bus.loadAddr = a[4:0];
        bus.loadData = d;
        tick();
        bus.loadEn   = 1'b0;
    endtask

    task automatic go(input int e);
        bus.start     = 1'b1;
        bus.endAddrIn = e[4:0];
        tick();
        bus.start     = 1'b0;
    endtask

    // {valid, pc, instr}
    task automatic expect_issue(input string tag,
                                input int pc,
                                input logic [3:0] ins);
        check(tag,
              {bus.instrValid, bus.pcOut, bus.instrOut},
              {1'b1, pc[4:0], ins});
    endtask

    // {done, busy, valid, instr}
    task automatic expect_done(input string tag);
        check(tag,
              {bus.done, bus.busy, bus.instrValid, bus.instrOut},
              {1'b1, 1'b0, 1'b0, 4'b0111});
    endtask

    initial begin
        logic [3:0] w;
        bus.loadEn    = 1'b0;
        bus.loadAddr  = '0;
        bus.loadData  = '0;
        bus.start     = 1'b0;
        bus.endAddrIn = '0;
        bus.stallIn   = 1'b0;
        bus.skipIn    = 1'b0;
        bus.stopIn    = 1'b0;

        // reset state
        do_reset();
        check("rst_state",
              {bus.instrOut, bus.pcOut, bus.instrValid,
               bus.busy, bus.done},
              {4'b0111, 5'd0, 1'b0, 1'b0, 1'b0});

        // 1: basic 3-word run
        load(0, 4'b0000);
        load(1, 4'b0001);
        load(2, 4'b1010);
        go(2);
        check("t1_start", {bus.busy, bus.instrValid}, 2'b10);
        tick(); expect_issue("t1_pc0", 0, 4'b0000);
        tick(); expect_issue("t1_pc1", 1, 4'b0001);
        tick(); expect_issue("t1_pc2", 2, 4'b1010);
        tick(); expect_done("t1_done");

        // 2: unwritten words read NOP; reset erases
        do_reset();
        load(0, 4'h1);
        load(1, 4'h2);
        load(2, 4'h3);
        load(3, 4'h4);
        go(5);
        tick(); expect_issue("t2_pc0", 0, 4'h1);
        tick(); expect_issue("t2_pc1", 1, 4'h2);
        tick(); expect_issue("t2_pc2", 2, 4'h3);
        tick(); expect_issue("t2_pc3", 3, 4'h4);
        tick(); expect_issue("t2_pc4", 4, 4'b0111);
        tick(); expect_issue("t2_pc5", 5, 4'b0111);
        do_reset();
        check("t2_rst", {bus.busy, bus.instrValid, bus.done}, 3'b000);
        go(0);
        tick(); expect_issue("t2_erased", 0, 4'b0111);
        tick(); expect_done("t2_end0");

        // 3: SNZ skip
        do_reset();
        load(0, 4'h1);
        load(1, 4'h2);
        load(2, 4'h3);
        load(3, 4'h8);
        load(4, 4'h9);
        load(5, 4'h5);
        go(5);
        tick(); expect_issue("t3_pc0", 0, 4'h1);
        tick(); expect_issue("t3_pc1", 1, 4'h2);
        tick(); expect_issue("t3_pc2", 2, 4'h3);
        tick(); expect_issue("t3_pc3", 3, 4'h8);
        bus.skipIn = 1'b1;
        tick(); expect_issue("t3_skip", 5, 4'h5);
        bus.skipIn = 1'b0;
        tick(); expect_done("t3_done");
        go(5);
        tick(); tick(); tick();
        tick(); expect_issue("t3_ns_pc3", 3, 4'h8);
        tick(); expect_issue("t3_ns_pc4", 4, 4'h9);
        tick(); tick(); expect_done("t3_ns_done");
        go(3);
        tick(); tick();
        tick(); expect_issue("t3_pe_pc2", 2, 4'h3);
        bus.skipIn = 1'b1;
        tick(); expect_done("t3_skip_end");
        bus.skipIn = 1'b0;

        // 4: stall holds, skip ignored while stalled
        go(5);
        tick(); expect_issue("t4_pc0", 0, 4'h1);
        tick(); expect_issue("t4_pc1", 1, 4'h2);
        bus.stallIn = 1'b1;
        bus.skipIn  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(); expect_issue("t4_stall", 1, 4'h2);
        end
        bus.stallIn = 1'b0;
        bus.skipIn  = 1'b0;
        tick(); expect_issue("t4_release", 2, 4'h3);
        bus.stopIn = 1'b1;
        tick();
        bus.stopIn = 1'b0;
        expect_done("t4_stop");

        // 5: load+start, load in RUN, stop
        do_reset();
        bus.loadEn    = 1'b1;
        bus.loadAddr  = 5'd7;
        bus.loadData  = 4'h6;
        bus.start     = 1'b1;
        bus.endAddrIn = 5'd2;
        tick();
        bus.loadEn = 1'b0;
        bus.start  = 1'b0;
        check("t5_idle", {bus.busy, bus.done}, 2'b00);
        go(7);
        bus.loadEn   = 1'b1;
        bus.loadAddr = 5'd7;
        bus.loadData = 4'hC;
        tick(); expect_issue("t5_pc0", 0, 4'b0111);
        bus.loadEn = 1'b0;
        for (int k = 1; k < 7; k++) tick();
        tick(); expect_issue("t5_readback", 7, 4'h6);
        tick(); expect_done("t5_done");
        go(7);
        tick();
        tick(); expect_issue("t5_pc1", 1, 4'b0111);
        bus.stopIn = 1'b1;
        tick();
        bus.stopIn = 1'b0;
        expect_done("t5_stop");
        check("t5_pc_held", {27'd0, bus.pcOut}, 32'd1);

        // 6: full-depth run or loop mode
        do_reset();
        for (int i = 0; i < 32; i++) begin
            w = i[3:0] ^ 4'h5;
            load(i, w);
        end
`ifdef PROGFETCH_LOOP_EN
        go(2);
        for (int k = 0; k < 8; k++) begin
            tick();
            w = (k % 3) ^ 4'h5;
            expect_issue("t6_loop", k % 3, w);
        end
        bus.stopIn = 1'b1;
        tick();
        bus.stopIn = 1'b0;
        expect_done("t6_loop_stop");
`else
        go(31);
        for (int i = 0; i < 32; i++) begin
            tick();
            w = i[3:0] ^ 4'h5;
            expect_issue("t6_issue", i, w);
        end
        tick(); expect_done("t6_done");
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/program_fetch_store.md
Name: program_fetch_store

Overview:
- Writable, parametrised program store with a built-in fetch sequencer. Replaces the fixed-content program ROMs.
- Program words are loaded through a write port while the block is not running.
- On start, the block issues one instruction per cycle to the CPU control path from address 0 up to a latched end address.
- Supports conditional skip (SNZ), stall and stop. Unwritten locations read as the NOP opcode (CLR).

Parameters:
- DATA_WIDTH, 4, instruction word width.
- ADDR_WIDTH, 5, address width. Depth = 2**ADDR_WIDTH.
- NOP_OPCODE, 4'b0111, word returned for unwritten locations and driven when idle. Width DATA_WIDTH.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- loadEn  in  1  write strobe for the program store.
- loadAddr  in  ADDR_WIDTH  write address.
- loadData  in  DATA_WIDTH  write data.
- start  in  1  begin execution from address 0.
- endAddrIn  in  ADDR_WIDTH  last address to execute; sampled on an accepted start.
- stallIn  in  1  CPU not ready; hold the current issue.
- skipIn  in  1  SNZ condition true for the instruction currently on instrOut.
- stopIn  in  1  terminate the run.
- instrOut  out  DATA_WIDTH  issued instruction (registered).
- pcOut  out  ADDR_WIDTH  address of instrOut.
- instrValid  out  1  instrOut is a live issue.
- busy  out  1  state == RUN.
- done  out  1  state == DONE.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - state = IDLE; all per-word written bits cleared; storage data is not cleared.
  - instrOut = NOP_OPCODE; pcOut = 0; instrValid = 0; busy = 0; done = 0; internal fetchPtr = 0.
- Storage read: word(a) = mem[a] if written[a], else NOP_OPCODE. Read is combinational and needs two read ports, at fetchPtr and fetchPtr+1.
- IDLE and DONE states:
  - loadEn: mem[loadAddr] <= loadData and written[loadAddr] <= 1 at the edge. A read-back issued later returns the new value.
  - start: latches endAddr <= endAddrIn, sets fetchPtr <= 0, moves to RUN. instrValid stays 0 on that edge.
  - loadEn and start in the same cycle: the load commits and start is ignored.
  - In DONE, instrValid = 0 and instrOut = NOP_OPCODE.
- RUN state: loadEn is ignored. Per edge, in priority order:
  1. stopIn: go to DONE. instrValid <= 0, instrOut <= NOP_OPCODE, pcOut held.
  2. stallIn: hold instrOut, pcOut, instrValid and fetchPtr. skipIn is ignored.
  3. Compute next address n = fetchPtr + (skipIn & instrValid ? 1 : 0), using ADDR_WIDTH+1-bit arithmetic.
     - If n > endAddr: go to DONE (same outputs as stopIn).
     - Otherwise: instrOut <= word(n), pcOut <= n, instrValid <= 1, fetchPtr <= n + 1.
- Skip behaviour: skipping costs no bubble. The skipped word never appears with instrValid = 1.
- Timing: latency from the start edge to the first valid issue is 1 cycle (addr 0 appears on the second edge after start is sampled).
- Edge cases:
  - endAddr = 0: exactly one issue, then DONE.
  - endAddr = 2**ADDR_WIDTH-1: fetchPtr overflow is caught by the extra bit. No wrap; go to DONE.
  - A skip that lands past endAddr ends the run without issuing.
  - start in DONE reruns the same program with a freshly sampled endAddrIn.
  - reset mid-run returns to IDLE and erases the program (all written bits cleared).

Optional Feature:
- Macro: PROGFETCH_LOOP_EN.
- Defined: when n > endAddr, continue at n - (endAddr+1) (the address wraps to 0, or to 1 after a skip) and stay in RUN. The wrapped word issues on the same edge. The run ends only via stopIn or reset.
- Undefined: DONE behaviour as specified in Behaviour. No wrap logic is synthesised.

Test Plan:
1. After reset, load addr0=4'b0000, addr1=4'b0001, addr2=4'b1010. Start with endAddrIn=2, no stalls -> valid issues (pc,instr) = (0,0000), (1,0001), (2,1010) on consecutive cycles, then done=1, instrValid=0, instrOut=0111.
2. Load addr0-3 only, start with endAddrIn=5 -> addr4 and addr5 issue 4'b0111 with instrValid=1. Reset mid-run, then start with endAddrIn=0 -> issues 4'b0111 (storage erased).
3. Program addr3=4'b1000 (SNZ). Pulse skipIn while pcOut=3 -> next issue is pc=5 with no bubble; pc=4 is never valid. Repeat with skipIn=0 -> pc=4 issues.
4. Hold stallIn high 3 cycles while pcOut=1 -> instrOut, pcOut, instrValid frozen. Assert skipIn during the stall -> ignored. Release -> pc=2 next.
5. loadEn together with start in IDLE -> word written, state stays IDLE. loadEn in RUN -> no change to storage on readback. stopIn at pc=1 -> DONE next edge.
6. endAddrIn=31 with all words loaded -> 32 issues then DONE, no wrap. With PROGFETCH_LOOP_EN and endAddrIn=2 -> pc sequence 0,1,2,0,1,2… until stopIn.
